// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: iterative RV32M multiply/divide sequencer beside EX.
// Multiplies use radix-2 shift-add. Divides use a restoring loop.
// Both take 32 CALC cycles. Divide-by-zero and signed overflow finish
// on a single-cycle fast path.
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_start              EX holds an M-ext op (held until o_done)
//   i_op                 funct3: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//   i_a, i_b             rs1 / rs2 operands
//   i_flush              abort the op in flight (EX flush)
//   o_stall              combinational pipeline freeze request
//   o_busy               iterating (CALC)
//   o_done               o_res valid this cycle (DONE)
//   o_res                registered result, held outside DONE
module ex_muldiv_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_res
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;     // product / quotient sign
  logic                rneg_q, rneg_d;   // remainder sign (dividend sign)
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;     // mul: {hi,lo} product; div: {rem,quot}
  logic [XLEN-1:0]     opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [XLEN-1:0]     res_q, res_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic              a_neg, b_neg, is_div;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nx, div_nx, step_nx, prod_fix;
  logic [XLEN:0]     rem_sh;
  logic [XLEN-1:0]   div_diff, quot_fix, rem_fix, calc_res;
  logic              div_ge;

  always_comb begin
    is_div = i_op[2];
    a_neg  = (i_op inside {3'd1, 3'd2, 3'd4, 3'd6}) & i_a[XLEN-1];
    b_neg  = (i_op inside {3'd1, 3'd4, 3'd6}) & i_b[XLEN-1];
    a_mag  = a_neg ? -i_a : i_a;
    b_mag  = b_neg ? -i_b : i_b;

    // Shift-add step: the carry out of the upper-half add becomes the new MSB.
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    mul_nx  = {mul_sum, acc_q[XLEN-1:1]};

    // Restoring step: the shifted remainder needs XLEN+1 bits.
    // On a failed trial it is known to fit back in XLEN bits.
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    div_ge   = rem_sh >= {1'b0, opnd_q};
    div_diff = rem_sh[XLEN-1:0] - opnd_q;
    div_nx   = div_ge ? {div_diff, acc_q[XLEN-2:0], 1'b1}
                      : {acc_q[2*XLEN-2:0], 1'b0};

    step_nx  = op_q[2] ? div_nx : mul_nx;

    // Sign correction applied on the last iteration's value.
    prod_fix = neg_q  ? -step_nx : step_nx;
    quot_fix = neg_q  ? -step_nx[XLEN-1:0] : step_nx[XLEN-1:0];
    rem_fix  = rneg_q ? -step_nx[2*XLEN-1:XLEN] : step_nx[2*XLEN-1:XLEN];
    case (op_q)
      3'd0:          calc_res = prod_fix[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:          calc_res = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:    calc_res = quot_fix;
      default:       calc_res = rem_fix;
    endcase

    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    res_d   = res_q;

    case (state_q)
      ST_IDLE: begin
        if (i_start && !i_flush) begin
          op_d   = i_op;
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          cnt_d  = '0;
          if (is_div && i_b == '0) begin
            res_d   = i_op[1] ? i_a : '1;
            state_d = ST_DONE;
          end else if (is_div && !i_op[0] && i_a == {1'b1, {(XLEN-1){1'b0}}}
                       && i_b == '1) begin
            res_d   = i_op[1] ? '0 : i_a;
            state_d = ST_DONE;
          end else begin
            state_d = ST_CALC;
            if (is_div) begin
              acc_d  = {{XLEN{1'b0}}, a_mag};
              opnd_d = b_mag;
            end else begin
              acc_d  = {{XLEN{1'b0}}, b_mag};
              opnd_d = a_mag;
            end
          end
        end
      end
      ST_CALC: begin
        acc_d = step_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          res_d   = calc_res;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush wins over any completion in the same cycle; o_res keeps its value.
    if (i_flush) begin
      state_d = ST_IDLE;
      res_d   = res_q;
    end

    done_d = (state_d == ST_DONE);
    busy_d = (state_d == ST_CALC);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign o_done  = done_q;
  assign o_busy  = busy_q;
  assign o_res   = res_q;
  assign o_stall = i_start & ~done_q & ~i_flush;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Scoreboard bench for ex_muldiv_seq. The driver queues the expected
// result and completion cycle for each issued op. A monitor pops an
// entry and checks it whenever o_done is seen.
module tb_ex_muldiv_seq;

  logic        clk = 1'b0;
  logic        i_rst, i_start, i_flush;
  logic [2:0]  i_op;
  logic [31:0] i_a, i_b;
  logic        o_stall, o_busy, o_done;
  logic [31:0] o_res;

  always #5 clk = ~clk;

  ex_muldiv_seq #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_op(i_op),
    .i_a(i_a), .i_b(i_b), .i_flush(i_flush),
    .o_stall(o_stall), .o_busy(o_busy), .o_done(o_done), .o_res(o_res)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] res;
    int          cyc;
  } exp_t;
  exp_t sb_q[$];
  logic [31:0] last_res;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: RV32M semantics computed with 64-bit integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (op)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Called at posedge+1 of cycle T with the DUT idle; returns at posedge+1 of the cycle after DONE.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int c, lat;
    logic [31:0] r;
    r   = ref_model(op, a, b);
    lat = is_fast(op, a, b) ? 1 : 33;
    i_op = op; i_a = a; i_b = b; i_start = 1'b1;
    c = cyc;
    sb_q.push_back('{op: op, res: r, cyc: c + lat});
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      check("stall", 32'(o_stall), 32'(k != lat));
      check("busy", 32'(o_busy), 32'(lat == 33 && k >= 1 && k <= 32));
    end
    last_res = r;
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    i_start = 1'b0;
    @(negedge clk);
    check("idle_stall", 32'(o_stall), 32'd0);
    check("idle_busy", 32'(o_busy), 32'd0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!i_rst && o_done) begin
      if (sb_q.size() == 0) begin
        n_tot++;
        $display("FAIL spurious_done: got o_done=1 with res %h, required no completion (cycle %0d)",
                 o_res, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check($sformatf("result_op%0d", e.op), o_res, e.res);
        check($sformatf("done_cycle_op%0d", e.op), 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    logic [2:0]  op;
    logic [31:0] a, b;
    int sel;

    i_rst = 1'b1; i_start = 1'b0; i_flush = 1'b0;
    i_op = '0; i_a = '0; i_b = '0; last_res = '0;
    repeat (3) @(posedge clk); #1;
    check("reset_done", 32'(o_done), 32'd0);
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_res", o_res, 32'd0);
    check("reset_stall", 32'(o_stall), 32'd0);
    i_rst = 1'b0;
    @(posedge clk); #1;

    // Directed ops, back-to-back with i_start held.
    run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD);
    run_op(3'd1, 32'h0000_0007, 32'hFFFF_FFFD);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd4, 32'hFFFF_FFEC, 32'd3);
    run_op(3'd6, 32'hFFFF_FFEC, 32'd3);
    run_op(3'd5, 32'd100, 32'd7);
    run_op(3'd7, 32'd100, 32'd7);
    run_op(3'd5, 32'd5, 32'd0);
    run_op(3'd6, 32'd5, 32'd0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    idle_cycle();

    // Flush of a DIV at T+10.
    i_op = 3'd4; i_a = 32'hFFFF_FFEC; i_b = 32'd3; i_start = 1'b1;
    c = cyc;
    repeat (10) @(posedge clk); #1;
    i_flush = 1'b1;
    @(negedge clk);
    check("flush_stall", 32'(o_stall), 32'd0);
    check("flush_busy_before", 32'(o_busy), 32'd1);
    @(posedge clk); #1;
    i_flush = 1'b0; i_start = 1'b0;
    @(negedge clk);
    check("flush_idle_busy", 32'(o_busy), 32'd0);
    check("flush_res_held", o_res, last_res);
    check("flush_cycle", 32'(cyc), 32'(c + 11));
    @(posedge clk); #1;
    run_op(3'd0, 32'd3, 32'd4);
    idle_cycle();

    // Reset mid-CALC with i_start held; op re-accepted after release.
    i_op = 3'd4; i_a = 32'd1000; i_b = 32'd7; i_start = 1'b1;
    repeat (20) @(posedge clk); #1;
    i_rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_res", o_res, 32'd0);
    check("rst_mid_busy", 32'(o_busy), 32'd0);
    check("rst_mid_done", 32'(o_done), 32'd0);
    i_rst = 1'b0;
    last_res = '0;
    run_op(3'd4, 32'd1000, 32'd7);
    idle_cycle();

    // Back-to-back pair.
    run_op(3'd0, 32'd2, 32'd2);
    run_op(3'd7, 32'd9, 32'd4);
    idle_cycle();

    // Randomized ops with corner-case biasing.
    for (int n = 0; n < 60; n++) begin
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (sel == 2) b = 32'($urandom_range(1, 15));
      if (sel == 3) a = 32'($urandom_range(0, 100));
      if (sel == 4) b = 32'hFFFF_FFFF;
      run_op(op, a, b);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    i_start = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
